// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares one single-port synchronous video RAM between the SVGA
//            display fetch path and a CPU access port. One byte is fetched
//            per 8-pixel group and shifted out MSB first as a 1-bit pixel
//            stream. The CPU gets every RAM cycle the display does not need.
// Ports    : clk, rst               - dot clock, synchronous active-high reset
//            hcount, vcount, vis    - position and visible flag from sync gen
//            cpu_req/we/addr/wdata  - CPU request, held until cpu_ack
//            cpu_ack, cpu_rdata     - one-cycle completion pulse, read data
//            ram_addr/we/wdata      - registered RAM control
//            ram_rdata              - RAM read data, one cycle after ram_addr
//            pix_out, pix_vis       - serialized pixel and aligned vis
// Options  : VRAM_CPU_BLANK_ONLY_EN - when defined, the CPU is granted only
//            while vis==0 (tear-free updates during blanking).
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int H_VISIBLE      = 800,
  parameter int V_VISIBLE      = 600,
  parameter int H_TOTAL        = 1056,
  parameter int V_TOTAL        = 628,
  parameter int ADDR_W         = 16,
  parameter int BYTES_PER_LINE = H_VISIBLE / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       hcount,
  input  logic [15:0]       vcount,
  input  logic              vis,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              pix_out,
  output logic              pix_vis
);

  localparam logic [15:0] GROUPS_PER_LINE = 16'(H_TOTAL / 8);
  localparam logic [15:0] LAST_LINE       = 16'(V_TOTAL - 1);
  localparam logic [15:0] ROWS_VIS        = 16'(V_VISIBLE);
  localparam logic [15:0] GROUPS_VIS      = 16'(BYTES_PER_LINE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  state_t     state;
  logic       op_we;       // latched direction of the access in flight
  logic       fetch_pend;  // a display fetch was issued in this group slot
  logic [7:0] pending;     // fetched byte waiting for its group to start
  logic [7:0] shift;       // serializer, MSB is the next pixel

  // Group-phase decode: decision edge, data capture edge, serializer load edge
  logic decide, capture, load;
  assign decide  = (hcount[2:0] == 3'd5);
  assign capture = (hcount[2:0] == 3'd7);
  assign load    = (hcount[2:0] == 3'd0);

  // The fetch always targets the group after the current one; the last
  // group of a line rolls over to group 0 of the next line.
  logic [15:0]       grp_inc, grp_next, row_next;
  logic              grp_wrap, do_fetch;
  logic [ADDR_W-1:0] fetch_addr;

  assign grp_inc  = {3'b000, hcount[15:3]} + 16'd1;
  assign grp_wrap = (grp_inc == GROUPS_PER_LINE);
  assign grp_next = grp_wrap ? 16'd0 : grp_inc;
  assign row_next = !grp_wrap              ? vcount :
                    (vcount == LAST_LINE)  ? 16'd0  : vcount + 16'd1;
  assign do_fetch = (grp_next < GROUPS_VIS) && (row_next < ROWS_VIS);
  assign fetch_addr = ADDR_W'(row_next) * ADDR_W'(BYTES_PER_LINE)
                    + ADDR_W'(grp_next);

  // The CPU never starts on a decision edge, so the display bus cycle that
  // follows it is always free.
  logic grant;
`ifdef VRAM_CPU_BLANK_ONLY_EN
  assign grant = cpu_req && !decide && !vis;
`else
  assign grant = cpu_req && !decide;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_we      <= 1'b0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= 8'h00;
      cpu_ack    <= 1'b0;
      cpu_rdata  <= 8'h00;
      fetch_pend <= 1'b0;
      pending    <= 8'h00;
      shift      <= 8'h00;
      pix_out    <= 1'b0;
      pix_vis    <= 1'b0;
    end else begin
      // CPU access sequencer
      case (state)
        S_IDLE: begin
          if (grant) begin
            ram_addr  <= cpu_addr;
            ram_we    <= cpu_we;
            ram_wdata <= cpu_wdata;
            op_we     <= cpu_we;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          ram_we <= 1'b0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (!op_we) cpu_rdata <= ram_rdata;
          cpu_ack <= 1'b1;
          state   <= S_ACK;
        end
        S_ACK: begin
          cpu_ack <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Display fetch. Cannot collide with a CPU issue: on a decision edge
      // the sequencer is either idle (grant blocked) or past its bus cycle.
      if (decide) begin
        fetch_pend <= do_fetch;
        if (do_fetch) begin
          ram_addr <= fetch_addr;
          ram_we   <= 1'b0;
        end
      end

      // Slots without a fetch contribute blank pixels
      if (capture) pending <= fetch_pend ? ram_rdata : 8'h00;

      // Serializer: pix_out shows the pixel of the previous cycle's hcount
      if (load) begin
        shift   <= {pending[6:0], 1'b0};
        pix_out <= vis & pending[7];
      end else begin
        shift   <= {shift[6:0], 1'b0};
        pix_out <= vis & shift[7];
      end
      pix_vis <= vis;
    end
  end

endmodule
`default_nettype wire
